// File: rtl/cpu_fetch.sv
// cpu_fetch: instruction fetch unit for a 16-bit-opcode CPU.
// Fetches big-endian halfwords from instruction memory and assembles
// short-form (one halfword) and long-form (opcode + 32-bit operand)
// instructions, presenting one at a time to decode.
//
// Ports:
//   clk_i            clock, all state updates on rising edge
//   rst_i            asynchronous active-low reset
//   imem_address_o   halfword address of the current memory request
//   imem_req_o       memory request strobe, held with address until ack
//   imem_ack_i       memory response strobe, imem_data_i valid with it
//   imem_data_i      fetched halfword
//   branch_flag_i    redirect request from execute (highest priority)
//   branch_target_i  redirect address, bit 0 ignored
//   stall_i          decode cannot accept the presented instruction
//   opcode_o         assembled opcode
//   operand_o        32-bit operand for long-form, 0 for short-form
//   valid_o          opcode_o/operand_o/PC_o carry a real instruction
//   PC_o             address of the opcode halfword
//
// Configuration:
//   CPU_FETCH_SKIP_NOP_EN  when defined, opcodes 0x0000-0x00FF are
//                          consumed without being presented.
module cpu_fetch (
    input  logic        clk_i,
    input  logic        rst_i,
    output logic [31:0] imem_address_o,
    output logic        imem_req_o,
    input  logic        imem_ack_i,
    input  logic [15:0] imem_data_i,
    input  logic        branch_flag_i,
    input  logic [31:0] branch_target_i,
    input  logic        stall_i,
    output logic [15:0] opcode_o,
    output logic [31:0] operand_o,
    output logic        valid_o,
    output logic [31:0] PC_o
);

    localparam int unsigned ADDR_W = 32;
    localparam int unsigned HW_W   = 16;
    localparam logic [ADDR_W-1:0] RESET_ADDR = 32'h0000_1000;

`ifdef CPU_FETCH_SKIP_NOP_EN
    localparam logic SKIP_NOP = 1'b1;
`else
    localparam logic SKIP_NOP = 1'b0;
`endif

    typedef enum logic [2:0] {
        FETCH_OP,
        FETCH_HI,
        FETCH_LO,
        HOLD,
        DISCARD
    } state_e;

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              req_q, req_d;
    logic [HW_W-1:0]   opcode_q, opcode_d;
    logic [ADDR_W-1:0] operand_q, operand_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic              valid_q, valid_d;
    logic [ADDR_W-1:0] tgt_q, tgt_d;

    logic [ADDR_W-1:0] addr_inc;
    logic [ADDR_W-1:0] br_addr;
    logic              xfer;

    // Opcodes followed by a 32-bit operand (high halfword first).
    function automatic logic is_long_op(input logic [HW_W-1:0] op);
        logic hit;
        case (op[15:8])
            8'h01, 8'h03, 8'h08, 8'h09, 8'h0C, 8'h0D, 8'h1A, 8'h1B,
            8'h1D, 8'h1F, 8'h20, 8'h22, 8'h24, 8'h30,
            8'h36, 8'h37, 8'h38, 8'h39: hit = 1'b1;
            default:                    hit = 1'b0;
        endcase
        return hit;
    endfunction

    assign addr_inc = addr_q + ADDR_W'(2);
    assign br_addr  = branch_target_i & 32'hFFFF_FFFE;
    assign xfer     = valid_q && !stall_i;

    // Next-state and next-output logic.
    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        req_d     = req_q;
        opcode_d  = opcode_q;
        operand_d = operand_q;
        pc_d      = pc_q;
        valid_d   = valid_q;
        tgt_d     = tgt_q;

        // A transferred instruction leaves the output stage.
        if (xfer) begin
            valid_d = 1'b0;
        end

        if (branch_flag_i) begin
            valid_d = 1'b0;
            if (req_q && !imem_ack_i) begin
                // Request in flight: must see its ack before redirecting.
                state_d = DISCARD;
                tgt_d   = br_addr;
            end else begin
                state_d = FETCH_OP;
                addr_d  = br_addr;
                req_d   = 1'b1;
            end
        end else begin
            case (state_q)
                FETCH_OP: begin
                    if (!req_q) begin
                        req_d = 1'b1;
                    end else if (valid_q && stall_i) begin
                        // Decode blocked: any halfword acked now is not
                        // accepted and is refetched after the hold.
                        state_d = HOLD;
                        if (imem_ack_i) begin
                            req_d = 1'b0;
                        end
                    end else if (imem_ack_i) begin
                        addr_d   = addr_inc;
                        pc_d     = addr_q;
                        opcode_d = imem_data_i;
                        if (is_long_op(imem_data_i)) begin
                            state_d = FETCH_HI;
                        end else if (!(SKIP_NOP && imem_data_i[15:8] == 8'h00)) begin
                            operand_d = '0;
                            valid_d   = 1'b1;
                        end
                    end
                end
                FETCH_HI: begin
                    if (imem_ack_i) begin
                        operand_d[31:16] = imem_data_i;
                        addr_d           = addr_inc;
                        state_d          = FETCH_LO;
                    end
                end
                FETCH_LO: begin
                    if (imem_ack_i) begin
                        operand_d[15:0] = imem_data_i;
                        addr_d          = addr_inc;
                        valid_d         = 1'b1;
                        state_d         = FETCH_OP;
                    end
                end
                HOLD: begin
                    if (req_q && imem_ack_i) begin
                        req_d = 1'b0;
                    end
                    if (!stall_i) begin
                        state_d = FETCH_OP;
                        req_d   = 1'b1;
                    end
                end
                DISCARD: begin
                    if (imem_ack_i) begin
                        state_d = FETCH_OP;
                        addr_d  = tgt_q;
                        req_d   = 1'b1;
                    end
                end
                default: begin
                    state_d = FETCH_OP;
                end
            endcase
        end
    end

    // State and output registers.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q   <= FETCH_OP;
            addr_q    <= RESET_ADDR;
            req_q     <= 1'b0;
            opcode_q  <= '0;
            operand_q <= '0;
            pc_q      <= '0;
            valid_q   <= 1'b0;
            tgt_q     <= '0;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            req_q     <= req_d;
            opcode_q  <= opcode_d;
            operand_q <= operand_d;
            pc_q      <= pc_d;
            valid_q   <= valid_d;
            tgt_q     <= tgt_d;
        end
    end

    assign imem_address_o = addr_q;
    assign imem_req_o     = req_q;
    assign opcode_o       = opcode_q;
    assign operand_o      = operand_q;
    assign valid_o        = valid_q;
    assign PC_o           = pc_q;

endmodule

// File: tb/tb_cpu_fetch.sv
// Self-checking bench for cpu_fetch: directed scenarios plus a randomized
// instruction stream compared against an instruction-level reference model.
module tb_cpu_fetch;
    logic        clk_i = 1'b0;
    logic        rst_i = 1'b0;
    logic [31:0] imem_address_o;
    logic        imem_req_o;
    logic        imem_ack_i = 1'b0;
    logic [15:0] imem_data_i = 16'h0;
    logic        branch_flag_i = 1'b0;
    logic [31:0] branch_target_i = 32'h0;
    logic        stall_i = 1'b0;
    logic [15:0] opcode_o;
    logic [31:0] operand_o;
    logic        valid_o;
    logic [31:0] PC_o;

    int n_checks = 0;
    int n_fail   = 0;

    logic [15:0] mem [logic [31:0]];
    int lat_min = 0, lat_max = 0, mcnt = 0, mlat = 0;

    localparam logic [7:0] LONG_OPS [18] = '{8'h01, 8'h03, 8'h08, 8'h09, 8'h0C, 8'h0D,
        8'h1A, 8'h1B, 8'h1D, 8'h1F, 8'h20, 8'h22, 8'h24, 8'h30, 8'h36, 8'h37, 8'h38, 8'h39};

`ifdef CPU_FETCH_SKIP_NOP_EN
    localparam bit SKIP_NOP = 1'b1;
`else
    localparam bit SKIP_NOP = 1'b0;
`endif

    cpu_fetch dut (
        .clk_i           (clk_i),
        .rst_i           (rst_i),
        .imem_address_o  (imem_address_o),
        .imem_req_o      (imem_req_o),
        .imem_ack_i      (imem_ack_i),
        .imem_data_i     (imem_data_i),
        .branch_flag_i   (branch_flag_i),
        .branch_target_i (branch_target_i),
        .stall_i         (stall_i),
        .opcode_o        (opcode_o),
        .operand_o       (operand_o),
        .valid_o         (valid_o),
        .PC_o            (PC_o)
    );

    always #5 clk_i = ~clk_i;

    // Unwritten locations read as a distinct short-form opcode.
    function automatic logic [15:0] mem_rd(input logic [31:0] a);
        if (mem.exists(a)) return mem[a];
        return {1'b1, a[15:1]};
    endfunction

    function automatic bit is_long_model(input logic [15:0] op);
        for (int i = 0; i < 18; i++) if (op[15:8] == LONG_OPS[i]) return 1'b1;
        return 1'b0;
    endfunction

    // Memory: ack after a per-request latency, data valid with ack.
    always @(negedge clk_i) begin
        if (!rst_i) begin
            imem_ack_i = 1'b0;
            mcnt = 0;
            mlat = lat_min;
        end else begin
            if (imem_ack_i) begin
                imem_ack_i = 1'b0;
                mcnt = 0;
                mlat = lat_min + int'($urandom_range(0, lat_max - lat_min));
            end
            if (imem_req_o) begin
                if (mcnt >= mlat) begin
                    imem_ack_i  = 1'b1;
                    imem_data_i = mem_rd(imem_address_o);
                end else begin
                    mcnt++;
                end
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    task automatic do_reset();
        @(negedge clk_i); #1;
        rst_i = 1'b0; stall_i = 1'b0; branch_flag_i = 1'b0; branch_target_i = 32'h0;
        repeat (2) @(negedge clk_i);
        #1 rst_i = 1'b1;
    endtask

    task automatic wait_valid(output logic ok);
        ok = 1'b0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk_i); #1;
            if (valid_o) begin ok = 1'b1; break; end
        end
    endtask

    task automatic test_reset();
        lat_min = 0; lat_max = 0; mem.delete();
        @(negedge clk_i); #1;
        n_checks++; if ({imem_req_o, valid_o} !== 2'b00) begin n_fail++; $display("FAIL reset_req_valid: got %b expected 00", {imem_req_o, valid_o}); end
        n_checks++; if (imem_address_o !== 32'h1000) begin n_fail++; $display("FAIL reset_addr: got %h expected 00001000", imem_address_o); end
        n_checks++; if ({opcode_o, operand_o, PC_o} !== 80'h0) begin n_fail++; $display("FAIL reset_outputs: got %h expected 0", {opcode_o, operand_o, PC_o}); end
        rst_i = 1'b1;
        repeat (4) @(negedge clk_i);
        #3 rst_i = 1'b0;
        #1;
        n_checks++; if ({imem_req_o, valid_o, imem_address_o, opcode_o, operand_o, PC_o} !== {2'b00, 32'h1000, 80'h0})
            begin n_fail++; $display("FAIL async_reset: got req=%b valid=%b addr=%h op=%h", imem_req_o, valid_o, imem_address_o, opcode_o); end
        @(negedge clk_i); #1 rst_i = 1'b1;
    endtask

    task automatic test_short();
        mem.delete(); mem[32'h1000] = 16'h2612; lat_min = 0; lat_max = 0;
        do_reset();
        @(negedge clk_i); #1;
        n_checks++; if ({imem_req_o, valid_o, imem_address_o} !== {2'b10, 32'h1000}) begin n_fail++; $display("FAIL first_req: got req=%b valid=%b addr=%h expected 1 0 00001000", imem_req_o, valid_o, imem_address_o); end
        @(negedge clk_i); #1;
        n_checks++; if ({valid_o, opcode_o, operand_o, PC_o} !== {1'b1, 16'h2612, 32'h0, 32'h1000}) begin n_fail++; $display("FAIL short_present: got v=%b op=%h opnd=%h pc=%h expected 1 2612 0 1000", valid_o, opcode_o, operand_o, PC_o); end
        n_checks++; if ({imem_req_o, imem_address_o} !== {1'b1, 32'h1002}) begin n_fail++; $display("FAIL short_continue: got req=%b addr=%h expected 1 00001002", imem_req_o, imem_address_o); end
    endtask

    task automatic test_long();
        logic ok;
        mem.delete(); lat_min = 0; lat_max = 0;
        mem[32'h1000] = 16'h0120; mem[32'h1002] = 16'hDEAD; mem[32'h1004] = 16'hBEEF; mem[32'h1006] = 16'h2612;
        do_reset();
        wait_valid(ok);
        n_checks++; if ({ok, opcode_o, operand_o, PC_o} !== {1'b1, 16'h0120, 32'hDEADBEEF, 32'h1000}) begin n_fail++; $display("FAIL long_present: got ok=%b op=%h opnd=%h pc=%h expected 1 0120 deadbeef 1000", ok, opcode_o, operand_o, PC_o); end
        wait_valid(ok);
        n_checks++; if ({ok, opcode_o, operand_o, PC_o} !== {1'b1, 16'h2612, 32'h0, 32'h1006}) begin n_fail++; $display("FAIL long_next: got ok=%b op=%h opnd=%h pc=%h expected 1 2612 0 1006", ok, opcode_o, operand_o, PC_o); end
    endtask

    task automatic test_stall();
        logic ok;
        logic [79:0] held;
        int n_first;
        logic seen_next;
        logic [47:0] next_xfer;
        mem.delete(); lat_min = 0; lat_max = 0;
        mem[32'h1000] = 16'h2612; mem[32'h1002] = 16'h2613;
        do_reset();
        wait_valid(ok);
        n_checks++; if (ok !== 1'b1) begin n_fail++; $display("FAIL stall_wait_valid: got %b expected 1", ok); end
        stall_i = 1'b1;
        held = {opcode_o, operand_o, PC_o};
        for (int k = 0; k < 3; k++) begin
            @(negedge clk_i); #1;
            n_checks++; if ({valid_o, imem_req_o, opcode_o, operand_o, PC_o} !== {2'b10, held}) begin n_fail++; $display("FAIL stall_hold%0d: got v=%b req=%b op=%h pc=%h expected 1 0 %h", k, valid_o, imem_req_o, opcode_o, PC_o, held); end
        end
        stall_i = 1'b0;
        n_first = 0; seen_next = 1'b0; next_xfer = 48'h0;
        for (int k = 0; k < 12; k++) begin
            if (k > 0) begin @(negedge clk_i); #1; end
            if (valid_o && PC_o == 32'h1000) n_first++;
            if (valid_o && PC_o != 32'h1000 && !seen_next) begin seen_next = 1'b1; next_xfer = {opcode_o, PC_o}; end
        end
        n_checks++; if (n_first !== 1) begin n_fail++; $display("FAIL stall_single_xfer: got %0d transfers expected 1", n_first); end
        n_checks++; if ({seen_next, next_xfer} !== {1'b1, 16'h2613, 32'h1002}) begin n_fail++; $display("FAIL stall_next: got %b %h expected 1 261300001002", seen_next, next_xfer); end
    endtask

    task automatic test_branch_discard();
        logic ok;
        mem.delete(); mem[32'h2000] = 16'h2612; lat_min = 2; lat_max = 2;
        do_reset();
        @(negedge clk_i); #1;
        branch_flag_i = 1'b1; branch_target_i = 32'h2001;
        @(negedge clk_i); #1;
        branch_flag_i = 1'b0;
        n_checks++; if ({imem_req_o, valid_o, imem_address_o} !== {2'b10, 32'h1000}) begin n_fail++; $display("FAIL discard_hold1: got req=%b v=%b addr=%h expected 1 0 1000", imem_req_o, valid_o, imem_address_o); end
        @(negedge clk_i); #1;
        n_checks++; if ({imem_req_o, valid_o, imem_address_o} !== {2'b10, 32'h1000}) begin n_fail++; $display("FAIL discard_hold2: got req=%b v=%b addr=%h expected 1 0 1000", imem_req_o, valid_o, imem_address_o); end
        @(negedge clk_i); #1;
        n_checks++; if ({imem_req_o, valid_o, imem_address_o} !== {2'b10, 32'h2000}) begin n_fail++; $display("FAIL discard_target: got req=%b v=%b addr=%h expected 1 0 2000", imem_req_o, valid_o, imem_address_o); end
        wait_valid(ok);
        n_checks++; if ({ok, opcode_o, PC_o} !== {1'b1, 16'h2612, 32'h2000}) begin n_fail++; $display("FAIL discard_first_valid: got ok=%b op=%h pc=%h expected 1 2612 2000", ok, opcode_o, PC_o); end
        // Second branch while discarding replaces the stored target.
        do_reset();
        @(negedge clk_i); #1;
        branch_flag_i = 1'b1; branch_target_i = 32'h3001;
        @(negedge clk_i); #1;
        branch_target_i = 32'h5005;
        @(negedge clk_i); #1;
        branch_flag_i = 1'b0;
        @(negedge clk_i); #1;
        n_checks++; if ({imem_req_o, valid_o, imem_address_o} !== {2'b10, 32'h5004}) begin n_fail++; $display("FAIL discard_retarget: got req=%b v=%b addr=%h expected 1 0 5004", imem_req_o, valid_o, imem_address_o); end
        lat_min = 0; lat_max = 0;
    endtask

    task automatic test_branch_lo();
        logic ok;
        logic bad;
        mem.delete(); lat_min = 0; lat_max = 0;
        mem[32'h1000] = 16'h1A00; mem[32'h1002] = 16'h1234; mem[32'h1004] = 16'h5678; mem[32'h4000] = 16'h2612;
        do_reset();
        bad = 1'b0;
        for (int k = 1; k <= 3; k++) begin
            @(negedge clk_i); #1;
            if (valid_o) bad = 1'b1;
            if (k == 3) begin branch_flag_i = 1'b1; branch_target_i = 32'h4000; end
        end
        @(negedge clk_i); #1;
        branch_flag_i = 1'b0;
        n_checks++; if ({bad, valid_o, imem_req_o, imem_address_o} !== {3'b001, 32'h4000}) begin n_fail++; $display("FAIL branch_lo_redirect: got early_valid=%b v=%b req=%b addr=%h expected 0 0 1 4000", bad, valid_o, imem_req_o, imem_address_o); end
        wait_valid(ok);
        n_checks++; if ({ok, opcode_o, operand_o, PC_o} !== {1'b1, 16'h2612, 32'h0, 32'h4000}) begin n_fail++; $display("FAIL branch_lo_first: got ok=%b op=%h opnd=%h pc=%h expected 1 2612 0 4000", ok, opcode_o, operand_o, PC_o); end
    endtask

    task automatic test_hold_branch();
        logic ok;
        mem.delete(); lat_min = 0; lat_max = 0;
        mem[32'h1000] = 16'h2612; mem[32'h6000] = 16'h2777;
        do_reset();
        wait_valid(ok);
        stall_i = 1'b1;
        @(negedge clk_i); #1;
        n_checks++; if ({ok, valid_o, imem_req_o} !== 3'b110) begin n_fail++; $display("FAIL hold_enter: got ok=%b v=%b req=%b expected 1 1 0", ok, valid_o, imem_req_o); end
        branch_flag_i = 1'b1; branch_target_i = 32'h6000;
        @(negedge clk_i); #1;
        branch_flag_i = 1'b0; stall_i = 1'b0;
        n_checks++; if ({valid_o, imem_req_o, imem_address_o} !== {2'b01, 32'h6000}) begin n_fail++; $display("FAIL hold_branch_drop: got v=%b req=%b addr=%h expected 0 1 6000", valid_o, imem_req_o, imem_address_o); end
        wait_valid(ok);
        n_checks++; if ({ok, opcode_o, PC_o} !== {1'b1, 16'h2777, 32'h6000}) begin n_fail++; $display("FAIL hold_branch_first: got ok=%b op=%h pc=%h expected 1 2777 6000", ok, opcode_o, PC_o); end
    endtask

    task automatic test_nop();
        logic ok;
        mem.delete(); lat_min = 0; lat_max = 0;
        mem[32'h1000] = 16'h0000; mem[32'h1002] = 16'h2612;
        do_reset();
        wait_valid(ok);
        if (!SKIP_NOP) begin
            n_checks++; if ({ok, opcode_o, PC_o} !== {1'b1, 16'h0000, 32'h1000}) begin n_fail++; $display("FAIL nop_presented: got ok=%b op=%h pc=%h expected 1 0000 1000", ok, opcode_o, PC_o); end
            wait_valid(ok);
        end
        n_checks++; if ({ok, opcode_o, PC_o} !== {1'b1, 16'h2612, 32'h1002}) begin n_fail++; $display("FAIL nop_next: got ok=%b op=%h pc=%h expected 1 2612 1002", ok, opcode_o, PC_o); end
    endtask

    task automatic test_wrap();
        logic ok;
        logic [31:0] exp_pc;
        mem.delete(); lat_min = 0; lat_max = 0;
        do_reset();
        @(negedge clk_i); #1;
        branch_flag_i = 1'b1; branch_target_i = 32'hFFFF_FFFD;
        @(negedge clk_i); #1;
        branch_flag_i = 1'b0;
        n_checks++; if (imem_address_o !== 32'hFFFF_FFFC) begin n_fail++; $display("FAIL wrap_target: got %h expected fffffffc", imem_address_o); end
        exp_pc = 32'hFFFF_FFFC;
        for (int k = 0; k < 3; k++) begin
            wait_valid(ok);
            n_checks++; if ({ok, PC_o, opcode_o} !== {1'b1, exp_pc, mem_rd(exp_pc)}) begin n_fail++; $display("FAIL wrap_pc%0d: got ok=%b pc=%h op=%h expected pc=%h op=%h", k, ok, PC_o, opcode_o, exp_pc, mem_rd(exp_pc)); end
            exp_pc = exp_pc + 32'd2;
        end
    endtask

    task automatic test_random();
        logic [79:0] exp_q[$];
        logic [79:0] e;
        logic [31:0] a;
        logic [15:0] op, hi, lo;
        logic [4:0]  idx;
        int          r;
        logic        prev_hold, prev_wait;
        logic [80:0] held;
        logic [31:0] wait_addr;
        mem.delete();
        a = 32'h1000;
        for (int i = 0; i < 60; i++) begin
            r = int'($urandom_range(0, 9));
            idx = 5'($urandom_range(0, 17));
            if (r < 3) op = {LONG_OPS[idx], 8'($urandom)};
            else if (r == 3) op = {8'h00, 8'($urandom)};
            else begin
                op = 16'($urandom);
                if (is_long_model(op)) op[15] = 1'b1;
            end
            mem[a] = op;
            hi = 16'h0; lo = 16'h0;
            if (is_long_model(op)) begin
                hi = 16'($urandom); lo = 16'($urandom);
                mem[a + 32'd2] = hi; mem[a + 32'd4] = lo;
            end
            if (!(SKIP_NOP && op[15:8] == 8'h00)) exp_q.push_back({a, op, hi, lo});
            a = a + (is_long_model(op) ? 32'd6 : 32'd2);
        end
        lat_min = 0; lat_max = 2;
        do_reset();
        prev_hold = 1'b0; prev_wait = 1'b0; held = '0; wait_addr = '0;
        for (int cyc = 0; cyc < 3000 && exp_q.size() > 0; cyc++) begin
            @(negedge clk_i); #1;
            if (prev_hold) begin
                n_checks++; if ({valid_o, opcode_o, operand_o, PC_o} !== held) begin n_fail++; $display("FAIL rand_hold_stable: got %h expected %h", {valid_o, opcode_o, operand_o, PC_o}, held); end
            end
            if (prev_wait) begin
                n_checks++; if ({imem_req_o, imem_address_o} !== {1'b1, wait_addr}) begin n_fail++; $display("FAIL rand_req_hold: got req=%b addr=%h expected 1 %h", imem_req_o, imem_address_o, wait_addr); end
            end
            stall_i = ($urandom_range(0, 3) == 0);
            if (valid_o && !stall_i) begin
                e = exp_q.pop_front();
                n_checks++; if ({PC_o, opcode_o, operand_o} !== e) begin n_fail++; $display("FAIL rand_xfer: got pc=%h op=%h opnd=%h expected %h", PC_o, opcode_o, operand_o, e); end
            end
            prev_hold = valid_o && stall_i;
            held      = {1'b1, opcode_o, operand_o, PC_o};
            prev_wait = imem_req_o && !imem_ack_i;
            wait_addr = imem_address_o;
        end
        stall_i = 1'b0;
        n_checks++; if (exp_q.size() != 0) begin n_fail++; $display("FAIL rand_timeout: got %0d instructions outstanding expected 0", exp_q.size()); end
        lat_min = 0; lat_max = 0;
    endtask

    initial begin
        test_reset();
        test_short();
        test_long();
        test_stall();
        test_branch_discard();
        test_branch_lo();
        test_hold_branch();
        test_nop();
        test_wrap();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
